// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: 32-step shift-add multiplier / restoring divider writing HI/LO for MIPS MULT(U)/DIV(U).
// Define MULDIV_SIGNED_EN to honour op_signed (magnitude iteration plus sign fix-up on the completion edge).
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    input  logic             hilo_read,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, a_mag, b_mag, diff;
    logic [WIDTH:0]     sum, shr;
    logic               ge;
    logic [2*WIDTH-1:0] res, res_fix;

    assign stall = busy & (hilo_read | start);

`ifdef MULDIV_SIGNED_EN
    logic neg_p_q, neg_r_q, sa, sb;
    assign sa    = op_signed & rs_val[WIDTH-1];
    assign sb    = op_signed & rt_val[WIDTH-1];
    assign a_mag = sa ? -rs_val : rs_val;
    assign b_mag = sb ? -rt_val : rt_val;
    assign res_fix = (state_q == DIV)
        ? {neg_r_q ? -res[2*WIDTH-1:WIDTH] : res[2*WIDTH-1:WIDTH], neg_p_q ? -res[WIDTH-1:0] : res[WIDTH-1:0]}
        : (neg_p_q ? -res : res);
`else
    logic unused_op_signed;
    assign unused_op_signed = op_signed;
    assign a_mag   = rs_val;
    assign b_mag   = rt_val;
    assign res_fix = res;
`endif

    // acc holds {carry, upper, multiplier} for MUL and {0, remainder, dividend/quotient} for DIV
    always_comb begin
        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
        shr   = acc_q[2*WIDTH-1:WIDTH-1];
        ge    = shr >= {1'b0, b_q};
        diff  = shr[WIDTH-1:0] - b_q;
        acc_d = (state_q == DIV) ? {1'b0, ge ? diff : shr[WIDTH-1:0], acc_q[WIDTH-2:0], ge}
              : acc_q[0]         ? {1'b0, sum, acc_q[WIDTH-1:1]}
              :                    {1'b0, acc_q[2*WIDTH:1]};
        res   = acc_d[2*WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            b_q         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_p_q     <= 1'b0;
            neg_r_q     <= 1'b0;
`endif
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            if (state_q == IDLE) begin
                if (start && !flush) begin
                    if (op_div && rt_val == '0) begin
                        hi          <= rs_val;
                        lo          <= '1;
                        done        <= 1'b1;
                        div_by_zero <= 1'b1;
                    end else begin
                        state_q <= op_div ? DIV : MUL;
                        busy    <= 1'b1;
                        cnt_q   <= '0;
                        acc_q   <= {{(WIDTH+1){1'b0}}, op_div ? a_mag : b_mag};
                        b_q     <= op_div ? b_mag : a_mag;
`ifdef MULDIV_SIGNED_EN
                        neg_p_q <= sa ^ sb;
                        neg_r_q <= sa;
`endif
                    end
                end
            end else if (flush) begin
                state_q <= IDLE;
                busy    <= 1'b0;
            end else begin
                acc_q <= acc_d;
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    state_q  <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    {hi, lo} <= res_fix;
                end
            end
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench; expected HI/LO queued at launch, popped on each done pulse.
module tb_muldiv_sequencer;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, op_div = 1'b0, op_signed = 1'b0;
    logic        flush = 1'b0, hilo_read = 1'b0;
    logic [31:0] rs_val = '0, rt_val = '0;
    logic        busy, done, div_by_zero, stall;
    logic [31:0] hi, lo;

    typedef struct {logic [31:0] hi; logic [31:0] lo; logic dbz;} exp_t;
    exp_t q[$];
    int chk_cnt = 0, pass_cnt = 0;

    muldiv_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op_div(op_div), .op_signed(op_signed),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .hilo_read(hilo_read),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) check("unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                check("hi", 64'(hi), 64'(e.hi));
                check("lo", 64'(lo), 64'(e.lo));
                check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
            end
        end else if (div_by_zero) check("dbz_without_done", 1, 0);
    end

    task automatic launch(input logic div, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic push, input logic [31:0] eh, input logic [31:0] el, input logic ed);
        exp_t e;
        start = 1'b1; op_div = div; op_signed = sgn; rs_val = a; rt_val = b;
        e.hi = eh; e.lo = el; e.dbz = ed;
        if (push) q.push_back(e);
        @(negedge clk);
        start = 1'b0; op_signed = 1'b0;
    endtask

    task automatic wait_done(output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (busy) busy_cycles++;
            @(negedge clk);
        end
        check("done_seen", 64'(done), 1);
        check("busy_at_done", 64'(busy), 0);
    endtask

    initial begin
        int n;
        logic [31:0] a, b;
        logic [63:0] p;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_hilo", {hi, lo}, 0);
        check("rst_dbz", 64'(div_by_zero), 0);
        reset = 1'b0;
        @(negedge clk);

        launch(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        wait_done(n);
        check("mul_busy_cycles", 64'(n), 32);

        launch(1'b1, 1'b0, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
        wait_done(n);
        check("div_busy_cycles", 64'(n), 32);
        start = 1'b1;
        #1 check("stall_idle_start", 64'(stall), 0);
        launch(1'b1, 1'b0, 32'h1234_5678, 32'h10, 1'b1, 32'h8, 32'h0123_4567, 1'b0);
        wait_done(n);
        check("b2b_busy_cycles", 64'(n), 32);

        launch(1'b1, 1'b0, 32'd5, 32'd0, 1'b1, 32'd5, 32'hFFFF_FFFF, 1'b1);
        check("dbz_busy", 64'(busy), 0);
        @(negedge clk);
        check("dbz_busy_after", 64'(busy), 0);

        launch(1'b0, 1'b0, 32'd3, 32'd5, 1'b1, 32'd0, 32'd15, 1'b0);
        hilo_read = 1'b1;
        #1 check("stall_hilo_read", 64'(stall), 1);
        hilo_read = 1'b0;
        #1 check("stall_quiet", 64'(stall), 0);
        start = 1'b1; op_div = 1'b1; rs_val = 32'd1; rt_val = 32'd0;
        #1 check("stall_start", 64'(stall), 1);
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        hilo_read = 1'b1;
        #1 check("stall_after_done", 64'(stall), 0);
        hilo_read = 1'b0;

        launch(1'b0, 1'b0, 32'h1234, 32'h5678, 1'b0, 0, 0, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 0);
        check("flush_hilo", {hi, lo}, 64'd15);
        repeat (40) @(negedge clk);
        check("flush_hilo_later", {hi, lo}, 64'd15);

        flush = 1'b1;
        launch(1'b1, 1'b0, 32'd9, 32'd0, 1'b0, 0, 0, 1'b0);
        flush = 1'b0;
        check("flush_start_done", 64'(done), 0);
        check("flush_start_busy", 64'(busy), 0);

        launch(1'b0, 1'b0, 32'hABCD, 32'h1234, 1'b0, 0, 0, 1'b0);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        #1 check("async_rst_hilo", {hi, lo}, 0);
        check("async_rst_busy", 64'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

`ifdef MULDIV_SIGNED_EN
        launch(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        wait_done(n);
        launch(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        wait_done(n);
        launch(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h8000_0000, 1'b0);
        wait_done(n);
`else
        launch(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd3, 1'b1, 32'h2, 32'hFFFF_FFEB, 1'b0);
        wait_done(n);
        launch(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h1, 32'h7FFF_FFFC, 1'b0);
        wait_done(n);
        launch(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0, 1'b0);
        wait_done(n);
`endif

        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = (i < 3) ? $urandom : ($urandom >> $urandom_range(0, 28)) | 32'h1;
            p = 64'(a) * 64'(b);
            if (i < 3) launch(1'b0, 1'b0, a, b, 1'b1, p[63:32], p[31:0], 1'b0);
            else launch(1'b1, 1'b0, a, b, 1'b1, a % b, a / b, 1'b0);
            wait_done(n);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(q.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
